// File: rtl/serial_pattern_ctrl.sv
// serial_pattern_ctrl
// Accepts parallel words over a valid/ready handshake and shifts each one out
// MSB first, one bit per clock. Every shifted bit also feeds a 4-bit sliding
// window that is compared against a pattern latched at word accept. Matches may
// overlap and may span word boundaries. Matches are counted in a saturating
// counter.
//
// Ports:
//   clk, n_rst          clock (rising edge), asynchronous active-low reset
//   clear               synchronous abort: drop the word in flight and zero the
//                       window, history and count
//   pattern[3:0]        target pattern, sampled when a word is accepted
//   in_valid, in_data   host word; it transfers when in_valid && in_ready
//   in_ready            high only in IDLE, decoded from the state register
//   serial_out          current bit; meaningful while shift_en=1
//   shift_en            high for each serial bit cycle
//   match               pulse in the cycle after the shifted bit that completed
//                       a match
//   word_done           pulse in the cycle after the last bit of a word
//   match_count         saturating match count since reset or clear
//   busy                state != IDLE
module serial_pattern_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic [3:0]        pattern,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              serial_out,
  output logic              shift_en,
  output logic              match,
  output logic              word_done,
  output logic [CNT_W-1:0]  match_count,
  output logic              busy
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0]    LAST_IDX = BW'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_shift;
  logic [BW-1:0]     r_bit_cnt;
  logic [3:0]        r_pat_q;
  // Only the three newest bits are stored. The oldest bit of the 4-bit window
  // is never consulted because the next window is {window[2:0], new_bit}.
  logic [2:0]        r_window;
  logic [2:0]        r_hist;
  logic              r_match;
  logic [CNT_W-1:0]  r_count;

  logic              w_load;
  logic              w_bit;
  logic [3:0]        w_win_nxt;
  logic              w_hit;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)     r_state <= IDLE;
    else if (clear) r_state <= IDLE;
    else            r_state <= w_next;
  end

  // Next state and decoded outputs
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    shift_en  = 1'b0;
    word_done = 1'b0;
    w_load    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load = 1'b1;
          w_next = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (r_bit_cnt == '0) w_next = DONE;
      end
      DONE: begin
        word_done = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_bit     = r_shift[DATA_W-1];
  assign w_win_nxt = {r_window, w_bit};
  // Only compare once at least three earlier bits exist, so the window is full.
  assign w_hit     = (r_hist >= 3'd3) && (w_win_nxt == r_pat_q);

  // Datapath. clear leaves the shift register, bit counter and latched pattern
  // alone because the next accept reloads all three.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_pat_q   <= '0;
      r_window  <= '0;
      r_hist    <= '0;
      r_match   <= 1'b0;
      r_count   <= '0;
    end else if (clear) begin
      r_window  <= '0;
      r_hist    <= '0;
      r_match   <= 1'b0;
      r_count   <= '0;
    end else begin
      r_match <= 1'b0;
      if (w_load) begin
        r_shift   <= in_data;
        r_pat_q   <= pattern;
        r_bit_cnt <= LAST_IDX;
      end
      if (shift_en) begin
        r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt - BW'(1);
        r_window  <= w_win_nxt[2:0];
        if (r_hist != 3'd4) r_hist <= r_hist + 3'd1;
        r_match   <= w_hit;
        // At saturation the match pulse is still emitted; only the count holds.
        if (w_hit && (r_count != CNT_MAX)) r_count <= r_count + CNT_W'(1);
      end
    end
  end

  // Gated so that a word abandoned by clear cannot leak stale bits.
  assign serial_out  = shift_en & w_bit;
  assign match       = r_match;
  assign match_count = r_count;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_serial_pattern_ctrl.sv
// Testbench for serial_pattern_ctrl. The stimulus process pushes the expected
// serial bits, match positions and word_done events into queues. A separate
// negedge monitor pops from those queues whenever the DUT presents an output.
module tb_serial_pattern_ctrl;
  localparam int DW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          clear = 1'b0;
  logic [3:0]    pattern = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, serial_out, shift_en, match, word_done, busy;
  logic [CW-1:0] match_count;

  serial_pattern_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .pattern(pattern),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .serial_out(serial_out), .shift_en(shift_en), .match(match),
    .word_done(word_done), .match_count(match_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic exp_bits[$];
  int   exp_match[$];   // encoded as seq*16 + bit index (1-based)
  int   exp_done[$];    // word sequence number
  int   sseq = 0;       // words accepted, counted by the stimulus process

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [DW-1:0] w, output int acc_cyc);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 100) begin step; n++; end
    acc_cyc = cyc;
    if (!in_ready) chk("send_ready_timeout", in_ready, 1);
    else begin
      step;
      acc_cyc = cyc;
      sseq++;
    end
    in_valid = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] w, input int nbits, input bit done);
    for (int i = 0; i < nbits; i++) exp_bits.push_back(w[DW-1-i]);
    if (done) exp_done.push_back(sseq);
  endtask

  task automatic exp_m(input int seq, input int b);
    exp_match.push_back(seq * 16 + b);
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (busy && n < 50) begin step; n++; end
    if (busy) chk("drain_timeout", busy, 0);
  endtask

  task automatic pulse_clear;
    clear = 1'b1; step; clear = 1'b0;
  endtask

  // Monitor: match and word_done refer to the most recently shifted bit, so they
  // are checked before this cycle's bit advances the position.
  initial begin
    int wseq, bidx, e;
    logic prev_shift, eb;
    wseq = 0; bidx = 0; prev_shift = 1'b0;
    forever begin
      @(negedge clk);
      if (match) begin
        if (exp_match.size() == 0) begin
          checks++; errors++;
          $display("FAIL match_unexpected: got seq %0d bit %0d expected none", wseq, bidx);
        end else begin
          e = exp_match.pop_front();
          chk("match_pos", wseq * 16 + bidx, e);
        end
      end
      if (word_done) begin
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL word_done_unexpected: got seq %0d expected none", wseq);
        end else begin
          e = exp_done.pop_front();
          chk("word_done_seq", wseq, e);
        end
      end
      if (shift_en) begin
        if (!prev_shift) begin wseq++; bidx = 1; end
        else bidx++;
        if (exp_bits.size() == 0) begin
          checks++; errors++;
          $display("FAIL bit_unexpected: got seq %0d bit %0d expected none", wseq, bidx);
        end else begin
          eb = exp_bits.pop_front();
          chk("serial_bit", serial_out, eb);
        end
      end
      prev_shift = shift_en;
    end
  end

  initial begin
    int a0, a1, nb, k;
    int acc[3];
    logic [DW-1:0] bpw[3];

    // Reset state
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_serial_out", serial_out, 0);
    chk("rst_shift_en", shift_en, 0);
    chk("rst_match", match, 0);
    chk("rst_word_done", word_done, 0);
    chk("rst_count", match_count, 0);
    chk("rst_busy", busy, 0);
    step; n_rst = 1'b1; step;

    // Basic overlap: 1101_1010 with pattern 1101 hits after bits 4 and 7
    pattern = 4'b1101;
    send(8'hDA, a0); push_word(8'hDA, 8, 1); exp_m(sseq, 4); exp_m(sseq, 7);
    drain;
    chk("basic_count", match_count, 2);

    // Cross-word: 03 then 40 hits only at bit 2 of the second word
    pulse_clear;
    send(8'h03, a0); push_word(8'h03, 8, 1);
    send(8'h40, a1); push_word(8'h40, 8, 1); exp_m(sseq, 2);
    chk("cross_accept_gap", a1 - a0, DW + 2);
    drain;
    chk("cross_count", match_count, 1);

    // Backpressure: in_valid stays high, and in_data is junk while not ready.
    // With pattern 1010, A5 3C F0 hits at (w1,b4) and (w2,b1).
    pulse_clear;
    pattern = 4'b1010;
    bpw[0] = 8'hA5; bpw[1] = 8'h3C; bpw[2] = 8'hF0;
    exp_m(sseq + 1, 4); exp_m(sseq + 2, 1);
    in_valid = 1'b1; k = 0; nb = 0;
    while (k < 3 && nb < 200) begin
      if (in_ready) begin
        in_data = bpw[k]; step; acc[k] = cyc; sseq++;
        push_word(bpw[k], 8, 1); k++;
      end else begin
        in_data = DW'($urandom); step;
      end
      nb++;
    end
    while (!in_ready && nb < 200) begin in_data = DW'($urandom); step; nb++; end
    in_valid = 1'b0;
    chk("bp_words_sent", k, 3);
    chk("bp_gap1", acc[1] - acc[0], DW + 2);
    chk("bp_gap2", acc[2] - acc[1], DW + 2);
    drain;
    chk("bp_count", match_count, 2);

    // in_valid together with clear must not be accepted
    in_valid = 1'b1; in_data = 8'hFF; clear = 1'b1; step;
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_blocks_accept", busy, 0);
    chk("clear_zero_count", match_count, 0);

    // Saturation: pattern 1111 with 52 words of FF. Every bit from the 4th on hits.
    pattern = 4'b1111;
    for (int w = 0; w < 52; w++) begin
      send(8'hFF, a0); push_word(8'hFF, 8, 1);
      for (int b = (w == 0) ? 4 : 1; b <= 8; b++) exp_m(sseq, b);
    end
    drain;
    chk("sat_count", match_count, 255);

    // Clear during bit 3 of D0
    pattern = 4'b1101;
    send(8'hD0, a0); push_word(8'hD0, 3, 0);
    step; step;
    clear = 1'b1; step; clear = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_in_ready", in_ready, 1);
    chk("clr_count", match_count, 0);
    chk("clr_match", match, 0);
    chk("clr_word_done", word_done, 0);
    // 0D hits only on its final bit, so match coincides with word_done
    send(8'h0D, a0); push_word(8'h0D, 8, 1); exp_m(sseq, 8);
    drain;
    chk("clr_next_count", match_count, 1);

    // Async reset during bit 3 of AB. The bit-3 hit must not surface as a match.
    send(8'hAB, a0); push_word(8'hAB, 3, 0);
    step; step; #5;
    n_rst = 1'b0; #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_shift_en", shift_en, 0);
    chk("arst_serial_out", serial_out, 0);
    chk("arst_match", match, 0);
    chk("arst_word_done", word_done, 0);
    chk("arst_count", match_count, 0);
    chk("arst_busy", busy, 0);
    step; n_rst = 1'b1; step; step;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_count", match_count, 0);
    chk("post_rst_match", match, 0);

    // All expected events must have been consumed
    chk("left_bits", exp_bits.size(), 0);
    chk("left_matches", exp_match.size(), 0);
    chk("left_done", exp_done.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
